// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - requester/adder bus for serial_add_ctrl; SERIAL_ADD_OVF_EN adds ovf
interface serial_add_ctrl_if #(
    parameter int W = 4
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer around one full_adder cell
// Optional two's-complement overflow output enabled by SERIAL_ADD_OVF_EN.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

module serial_add_ctrl #(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  sha_q, sha_d;
    logic [W-1:0]  shb_q, shb_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    logic          fa_s, fa_co;
    logic          accept;
    logic          last;
    logic [W-1:0]  sha_shift;

    full_adder u_fa (
        .a_i  (sha_q[0]),
        .b_i  (shb_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    assign accept = bus.start && (state_q != RUN);
    assign last   = (state_q == RUN) && (cnt_q == CW'(W - 1));

    // The A register doubles as the sum shift register: each consumed A bit
    // leaves at the LSB while the new sum bit enters at the MSB.
    generate
        if (W == 1) begin : g_w1
            assign sha_shift = fa_s;
        end else begin : g_wn
            assign sha_shift = {fa_s, sha_q[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        sha_d   = sha_q;
        shb_d   = shb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (accept) begin
            sha_d   = bus.a;
            shb_d   = bus.b;
            carry_d = bus.cin;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            sha_d   = sha_shift;
            shb_d   = shb_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + 1'b1;
            // Results are only published on entry to DONE so they stay stable
            // through IDLE and the following RUN.
            if (last) begin
                sum_d  = sha_shift;
                cout_d = fa_co;
`ifdef SERIAL_ADD_OVF_EN
                ovf_d  = carry_q ^ fa_co;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sha_q   <= '0;
            shb_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule
